// File: rtl/demux_stream_nch.sv
// demux_stream_nch: registered 1-to-N stream demux with
// per-channel holding register, broadcast and bad-select drop.
module demux_stream_nch #(
  parameter int DATA_W = 8,
  parameter int N_CH   = 4,
  parameter int SEL_W  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic                     in_bcast,
  output logic [N_CH-1:0]          out_valid,
  input  logic [N_CH-1:0]          out_ready,
  output logic [N_CH*DATA_W-1:0]   out_data,
  output logic [7:0]               err_cnt
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } ch_state_e;

  ch_state_e         state_q [N_CH];
  ch_state_e         state_d [N_CH];
  logic [DATA_W-1:0] data_q  [N_CH];
  logic [N_CH-1:0]   free;
  logic [N_CH-1:0]   load;
  logic              sel_ok;
  logic              sel_free;
  logic              take;
  logic              drop;
  logic [7:0]        err_q;

  assign sel_ok = ({1'b0, in_sel} < (SEL_W+1)'(N_CH));

  // A draining FULL channel counts as free for full throughput.
  always_comb begin
    free     = '0;
    sel_free = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      free[k] = (state_q[k] == EMPTY) | out_ready[k];
      if (in_sel == SEL_W'(k)) sel_free = free[k];
    end
  end

  always_comb begin
    in_ready = 1'b1;
    unique case (1'b1)
      in_bcast:            in_ready = &free;
      (!in_bcast & sel_ok): in_ready = sel_free;
      default:             in_ready = 1'b1;
    endcase
  end

  assign take = in_valid & in_ready;
  assign drop = take & ~in_bcast & ~sel_ok;

  always_comb begin
    load = '0;
    for (int k = 0; k < N_CH; k++) begin
      load[k] = take &
        (in_bcast | (sel_ok & (in_sel == SEL_W'(k))));
    end
  end

  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      state_d[k] = state_q[k];
      unique case (state_q[k])
        EMPTY: state_d[k] = load[k] ? FULL : EMPTY;
        FULL:  state_d[k] = (load[k] | ~out_ready[k])
                            ? FULL : EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_CH; k++) begin
        state_q[k] <= EMPTY;
        data_q[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        state_q[k] <= state_d[k];
        if (load[k]) data_q[k] <= in_data;
      end
    end
  end

  // Saturate rather than wrap so a flood of bad selects stays visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= '0;
    end else if (drop && err_q != 8'hFF) begin
      err_q <= err_q + 8'd1;
    end
  end

  always_comb begin
    out_valid = '0;
    out_data  = '0;
    for (int k = 0; k < N_CH; k++) begin
      out_valid[k] = (state_q[k] == FULL);
      out_data[k*DATA_W +: DATA_W] = data_q[k];
    end
  end

  assign err_cnt = err_q;

endmodule

// File: tb/tb_demux_stream_nch.sv
// tb_demux_stream_nch: directed and random checks of the
// 4-channel demux plus a 3-channel copy for bad selects.
module tb_demux_stream_nch;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [1:0]  in_sel;
  logic        in_bcast;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [31:0] out_data;
  logic [7:0]  err_cnt;

  logic        v3;
  logic        r3;
  logic [7:0]  d3;
  logic [1:0]  s3;
  logic        b3;
  logic [2:0]  ov3;
  logic [2:0]  or3;
  logic [23:0] od3;
  logic [7:0]  e3;

  int tests = 0;
  int fails = 0;

  bit         m_v [4];
  logic [7:0] m_d [4];

  demux_stream_nch #(.DATA_W(8), .N_CH(4), .SEL_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .in_bcast(in_bcast),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .err_cnt(err_cnt)
  );

  demux_stream_nch #(.DATA_W(8), .N_CH(3), .SEL_W(2)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v3), .in_ready(r3),
    .in_data(d3), .in_sel(s3), .in_bcast(b3),
    .out_valid(ov3), .out_ready(or3),
    .out_data(od3), .err_cnt(e3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run still going at %0t", $time);
    $fatal(1, "timeout");
  end

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_v[k] = 1'b0;
      m_d[k] = 8'h00;
    end
  endtask

  function automatic logic exp_ready();
    int nfree = 0;
    for (int k = 0; k < 4; k++)
      if (!m_v[k] || out_ready[k]) nfree++;
    if (in_bcast) return (nfree == 4);
    return (!m_v[in_sel] || out_ready[in_sel]);
  endfunction

  function automatic logic [3:0] exp_valid();
    logic [3:0] r = '0;
    for (int k = 0; k < 4; k++) r[k] = m_v[k];
    return r;
  endfunction

  function automatic logic [31:0] exp_data();
    logic [31:0] r = '0;
    for (int k = 0; k < 4; k++) r[k*8 +: 8] = m_d[k];
    return r;
  endfunction

  // Advance one edge; the model sees the same pre-edge inputs.
  task automatic tick();
    bit         nv [4];
    logic [7:0] nd [4];
    logic       took;
    took = in_valid && exp_ready();
    for (int k = 0; k < 4; k++) begin
      nv[k] = m_v[k] && !out_ready[k];
      nd[k] = m_d[k];
      if (took && (in_bcast || in_sel == 2'(k))) begin
        nv[k] = 1'b1;
        nd[k] = in_data;
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      m_v[k] = nv[k];
      m_d[k] = nd[k];
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 0; in_data = 0; in_sel = 0; in_bcast = 0;
    out_ready = 4'h0;
    v3 = 0; d3 = 0; s3 = 0; b3 = 0; or3 = 3'b000;
    model_reset();
    #3;
    tests++;
    if (out_valid !== 4'b0000) begin
      fails++;
      $display("FAIL rst_valid: got %b want 0000", out_valid);
    end
    tests++;
    if (out_data !== 32'h0) begin
      fails++;
      $display("FAIL rst_data: got %h want 0", out_data);
    end
    tests++;
    if (err_cnt !== 8'd0) begin
      fails++;
      $display("FAIL rst_err: got %0d want 0", err_cnt);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if (out_valid !== 4'b0000 || out_data !== 32'h0) begin
      fails++;
      $display("FAIL idle_out: got %b/%h want 0000/0",
               out_valid, out_data);
    end
    for (int s = 0; s < 4; s++) begin
      in_sel = 2'(s);
      #1;
      tests++;
      if (in_ready !== 1'b1) begin
        fails++;
        $display("FAIL idle_ready sel%0d: got %b want 1",
                 s, in_ready);
      end
    end
  endtask

  task automatic test_unicast_stream();
    logic [7:0] w [3] = '{8'h11, 8'h22, 8'h33};
    logic [1:0] s [3] = '{2'd0, 2'd1, 2'd3};
    logic [3:0] want;
    out_ready = 4'hF;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = w[i]; in_sel = s[i];
      #1;
      tests++;
      if (in_ready !== 1'b1) begin
        fails++;
        $display("FAIL uni_stall %0d: got %b want 1", i, in_ready);
      end
      tick();
      want = 4'b0001 << s[i];
      tests++;
      if (out_valid !== want ||
          out_data[s[i]*8 +: 8] !== w[i]) begin
        fails++;
        $display("FAIL uni_out %0d: got %b/%h want %b/%h", i,
                 out_valid, out_data[s[i]*8 +: 8], want, w[i]);
      end
    end
    in_valid = 1'b0;
    tick();
    tests++;
    if (out_valid !== exp_valid() || out_data !== exp_data()) begin
      fails++;
      $display("FAIL uni_drain: got %b/%h want %b/%h",
               out_valid, out_data, exp_valid(), exp_data());
    end
  endtask

  task automatic test_backpressure();
    out_ready = 4'b1011;
    in_valid = 1'b1; in_data = 8'hA5; in_sel = 2'd2;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_first: got %b want 1", in_ready);
    end
    tick();
    in_data = 8'h5A;
    #1;
    tests++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL bp_stall: got %b want 0", in_ready);
    end
    tick();
    tests++;
    if (out_valid[2] !== 1'b1 || out_data[23:16] !== 8'hA5) begin
      fails++;
      $display("FAIL bp_hold: got %b/%h want 1/a5",
               out_valid[2], out_data[23:16]);
    end
    out_ready[2] = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_release: got %b want 1", in_ready);
    end
    tick();
    tests++;
    if (out_valid !== 4'b0100 || out_data[23:16] !== 8'h5A) begin
      fails++;
      $display("FAIL bp_next: got %b/%h want 0100/5a",
               out_valid, out_data[23:16]);
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_broadcast();
    out_ready = 4'b1011;
    in_valid = 1'b1; in_data = 8'h77; in_sel = 2'd2;
    tick();
    in_bcast = 1'b1; in_data = 8'hC3; in_sel = 2'd0;
    #1;
    tests++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL bc_block: got %b want 0", in_ready);
    end
    tick();
    tests++;
    if (out_valid !== 4'b0100 || out_data !== exp_data()) begin
      fails++;
      $display("FAIL bc_none: got %b/%h want 0100/%h",
               out_valid, out_data, exp_data());
    end
    out_ready = 4'hF;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL bc_go: got %b want 1", in_ready);
    end
    tick();
    tests++;
    if (out_valid !== 4'hF || out_data !== 32'hC3C3C3C3) begin
      fails++;
      $display("FAIL bc_all: got %b/%h want 1111/c3c3c3c3",
               out_valid, out_data);
    end
    in_valid = 1'b0; in_bcast = 1'b0;
    tick();
  endtask

  task automatic test_out_of_range();
    int want;
    or3 = 3'b000;
    v3 = 1'b1; d3 = 8'h9E; s3 = 2'd1; b3 = 1'b0;
    @(posedge clk);
    #1;
    s3 = 2'd3;
    for (int i = 0; i < 300; i++) begin
      d3 = 8'($urandom);
      #1;
      want = (i > 255) ? 255 : i;
      tests++;
      if (r3 !== 1'b1 || ov3 !== 3'b010 || e3 !== 8'(want)) begin
        fails++;
        $display("FAIL oor %0d: got r=%b v=%b e=%0d want 1/010/%0d",
                 i, r3, ov3, e3, want);
      end
      @(posedge clk);
      #1;
    end
    v3 = 1'b0;
    tests++;
    if (e3 !== 8'd255 || od3[15:8] !== 8'h9E) begin
      fails++;
      $display("FAIL oor_sat: got %0d/%h want 255/9e",
               e3, od3[15:8]);
    end
  endtask

  task automatic test_async_reset();
    out_ready = 4'h0;
    in_valid = 1'b1; in_data = 8'h01; in_sel = 2'd0;
    tick();
    in_data = 8'h02; in_sel = 2'd1;
    tick();
    in_valid = 1'b0;
    tests++;
    if (out_valid !== 4'b0011) begin
      fails++;
      $display("FAIL ar_pre: got %b want 0011", out_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    tests++;
    if (out_valid !== 4'b0000 || out_data !== 32'h0 ||
        err_cnt !== 8'd0 || e3 !== 8'd0) begin
      fails++;
      $display("FAIL ar_clear: got %b/%h/%0d/%0d want 0000/0/0/0",
               out_valid, out_data, err_cnt, e3);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 4'hF;
    in_valid = 1'b1; in_data = 8'h44; in_sel = 2'd3;
    tick();
    in_valid = 1'b0;
    tests++;
    if (out_valid !== 4'b1000 || out_data[31:24] !== 8'h44) begin
      fails++;
      $display("FAIL ar_resume: got %b/%h want 1000/44",
               out_valid, out_data[31:24]);
    end
  endtask

  task automatic test_random();
    logic stalled = 1'b0;
    for (int i = 0; i < 400; i++) begin
      out_ready = 4'($urandom);
      if (!stalled) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = 8'($urandom);
        in_sel   = 2'($urandom);
        in_bcast = ($urandom_range(0, 7) == 0);
      end
      #1;
      tests++;
      if (in_ready !== exp_ready()) begin
        fails++;
        $display("FAIL rnd_ready %0d: got %b want %b",
                 i, in_ready, exp_ready());
      end
      stalled = in_valid && !exp_ready();
      tick();
      tests++;
      if (out_valid !== exp_valid() || out_data !== exp_data() ||
          err_cnt !== 8'd0) begin
        fails++;
        $display("FAIL rnd_out %0d: got %b/%h/%0d want %b/%h/0",
                 i, out_valid, out_data, err_cnt,
                 exp_valid(), exp_data());
      end
    end
    in_valid = 1'b0; in_bcast = 1'b0;
  endtask

  initial begin
    test_reset();
    test_unicast_stream();
    test_backpressure();
    test_broadcast();
    test_out_of_range();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/demux_stream_nch.md
Name: demux_stream_nch

Overview:
- Parametrised, registered 1-to-N demultiplexer with a valid/ready handshake on every port.
- Successor to the combinational 1-to-2 gate-level demux, adding:
  - width and channel-count generalisation;
  - a one-entry holding register per output channel;
  - a broadcast mode;
  - out-of-range select detection.
- Sits between a single producer stream and N independent consumers, e.g. the lab datapath steering operands to functional units.

Parameters:
- DATA_W, 8, payload width in bits (>=1).
- N_CH, 4, number of output channels (2..16).
- SEL_W, 2, select width; must satisfy 2**SEL_W >= N_CH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  producer has a word.
- in_ready  output  1  block accepts the word this cycle.
- in_data  input  DATA_W  payload.
- in_sel  input  SEL_W  destination channel index (unicast).
- in_bcast  input  1  1 = copy the word to all channels; in_sel is ignored.
- out_valid  output  N_CH  per-channel word present.
- out_ready  input  N_CH  per-channel consumer accepts.
- out_data  output  N_CH*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W].
- err_cnt  output  8  saturating count of dropped out-of-range words.

Behaviour:

Reset and clocking:
- One clock. Reset is asynchronous and active-low (rst_n); clk is the only clock.
- While rst_n=0: out_valid=0, out_data=0, err_cnt=0.
- in_ready is combinational and holds no state.
- Reset asserted mid-operation discards all held words immediately. No output transfer completes in a cycle where rst_n=0.

Channel state:
- Each channel k is a 2-state machine: EMPTY (out_valid[k]=0) or FULL (out_valid[k]=1).
- free[k] = ~out_valid[k] | out_ready[k]. A FULL channel being drained this cycle counts as free, giving full throughput.

Acceptance:
- Unicast, in_sel < N_CH: in_ready = free[in_sel].
- Broadcast: in_ready = AND of free[k] over all k. All channels load together or none do; there are no partial broadcasts.
- Unicast, in_sel >= N_CH (only possible when N_CH is not a power of two): in_ready=1 and the word is dropped.
  - No channel changes.
  - err_cnt increments by 1, saturating at 255. It never wraps.
- in_ready does not depend on in_valid. It may depend on in_sel, in_bcast and out_ready.
- A transfer occurs when in_valid & in_ready at the rising edge.

Latency and transitions:
- Latency is 1 cycle: a word accepted at edge t appears on out_data/out_valid of its target after edge t.
- Per channel at each edge:
  - Load and drain in the same cycle (FULL, out_ready[k]=1, new word targeted): stays FULL with the new data. No bubble and no loss.
  - Load only: EMPTY->FULL.
  - Drain only (out_ready[k]=1, no load): FULL->EMPTY. out_data[k] holds its last value.
  - Neither: no change.

Data stability and ordering:
- While out_valid[k]=1 and out_ready[k]=0, out_data[k] and out_valid[k] are held stable.
- Order is preserved per channel. No ordering is guaranteed across channels.
- out_ready on an EMPTY channel has no effect.

Producer obligation (not checked by the block):
- in_data, in_sel and in_bcast stay stable while in_valid=1 and in_ready=0.

Test Plan:
- Reset/idle: rst_n=0, then release with in_valid=0 -> out_valid=4'b0000, out_data=0, err_cnt=0. in_ready=1 for any in_sel.
- Unicast streaming: all out_ready=1; send 0x11 sel 0, 0x22 sel 1, 0x33 sel 3 on consecutive edges -> each appears one cycle later on its channel only, with zero stall cycles.
- Backpressure: out_ready[2]=0; send 0xA5 sel 2, then 0x5A sel 2 ->
  - in_ready drops to 0 for the second word and 0xA5 is held on channel 2;
  - raising out_ready[2] accepts 0x5A in that same cycle, and channel 2 shows 0x5A the next cycle.
- Broadcast: out_ready=4'b1011 with channel 2 FULL; in_bcast=1, data 0xC3 ->
  - in_ready=0 and no channel loads;
  - after out_ready[2]=1, all four channels show 0xC3 the next cycle.
- Out-of-range: N_CH=3, SEL_W=2; 300 words with in_sel=3 -> in_ready=1 throughout, no out_valid change, err_cnt=255 (saturated).
- Async reset mid-stream: assert rst_n=0 between edges while channels 0 and 1 are FULL -> out_valid clears immediately without waiting for a clock edge. After release, normal traffic resumes.
